// File: rtl/car_motion_ctrl_if.sv
// Target/door-button inputs and floor/status outputs of the car motion sequencer.
// The controller connects through the slave modport; its driver uses master.
interface car_motion_ctrl_if;
  logic [2:0] input_des;
  logic       input_bool;
  logic       input_door_hold;
  logic [2:0] output_now;
  logic       output_dir;
  logic       output_moving;
  logic       output_door_open;
  logic       output_arrive;

  modport master (
    output input_des, input_bool, input_door_hold,
    input  output_now, output_dir, output_moving, output_door_open, output_arrive
  );

  modport slave (
    input  input_des, input_bool, input_door_hold,
    output output_now, output_dir, output_moving, output_door_open, output_arrive
  );
endinterface

// File: rtl/car_motion_ctrl.sv
// Car motion and door sequencer: steps one floor per travel period toward the
// target and runs a timed door cycle on arrival, feeding floor/direction back upstream.
module car_motion_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 50_000_000,
  parameter int unsigned DOOR_CYCLES   = 150_000_000,
  parameter int unsigned TOP_FLOOR     = 6
) (
  input  logic                input_clk,
  input  logic                input_rst_n,
  car_motion_ctrl_if.slave    bus
);

  localparam int unsigned CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [2:0]       TOP         = 3'(TOP_FLOOR);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t           state_q, state_d;
  logic [2:0]       now_q, now_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             moving_q, door_q, arrive_q, arrive_d;

  logic [2:0]       next_floor;
  logic             target_ok, beyond, end_floor;

  // Floor reached at the end of the current segment, clamped to the shaft.
  always_comb begin
    next_floor = now_q;
    if (dir_q && (now_q < TOP))
      next_floor = now_q + 3'd1;
    else if (!dir_q && (now_q > 3'd1))
      next_floor = now_q - 3'd1;
    target_ok = bus.input_bool && (bus.input_des >= 3'd1) && (bus.input_des <= TOP);
    beyond    = dir_q ? (bus.input_des > next_floor) : (bus.input_des < next_floor);
    end_floor = (next_floor == 3'd1) || (next_floor == TOP);
  end

  always_comb begin
    state_d  = state_q;
    now_d    = now_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    arrive_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (target_ok) begin
          cnt_d = '0;
          if (bus.input_des == now_q) begin
            state_d  = DOOR;
            arrive_d = 1'b1;
          end else begin
            state_d = MOVE;
            dir_d   = (bus.input_des > now_q);
          end
        end
      end
      MOVE: begin
        if (cnt_q == TRAVEL_LAST) begin
          // Segment complete: commit the new floor and decide on the same edge.
          cnt_d = '0;
          now_d = next_floor;
          if (target_ok && (bus.input_des == next_floor)) begin
            state_d  = DOOR;
            arrive_d = 1'b1;
          end else if (!(target_ok && beyond && !end_floor)) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOOR: begin
        if (bus.input_door_hold) begin
          cnt_d = '0;
        end else if (cnt_q == DOOR_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (!input_rst_n) begin
      state_q  <= IDLE;
      now_q    <= 3'd1;
      dir_q    <= 1'b1;
      cnt_q    <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      arrive_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      now_q    <= now_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      moving_q <= (state_d == MOVE);
      door_q   <= (state_d == DOOR);
      arrive_q <= arrive_d;
    end
  end

  assign bus.output_now       = now_q;
  assign bus.output_dir       = dir_q;
  assign bus.output_moving    = moving_q;
  assign bus.output_door_open = door_q;
  assign bus.output_arrive    = arrive_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl with short travel/door periods:
// a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_car_motion_ctrl;
  localparam int unsigned TC = 4;
  localparam int unsigned DC = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  car_motion_ctrl_if bus ();

  car_motion_ctrl #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .TOP_FLOOR(6)) dut (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .bus         (bus)
  );

  // One cycle: inputs applied, then outputs {now,dir,moving,door_open,arrive} expected after the edge.
  typedef struct {
    logic       rst;
    logic [2:0] des;
    logic       vld;
    logic       hold;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input int des, input logic vld, input logic hold,
                             input int now, input logic dir, input logic m, input logic d,
                             input logic a);
    vec_t t;
    t.rst  = r;
    t.des  = 3'(des);
    t.vld  = vld;
    t.hold = hold;
    t.exp  = {3'(now), dir, m, d, a};
    return t;
  endfunction

  task automatic apply(input logic r, input int des, input logic vld, input logic hold);
    rst_n               = r;
    bus.input_des       = 3'(des);
    bus.input_bool      = vld;
    bus.input_door_hold = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] exp);
    logic [6:0] act;
    act = {bus.output_now, bus.output_dir, bus.output_moving, bus.output_door_open, bus.output_arrive};
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got now=%0d dir=%b mov=%b door=%b arr=%b, want now=%0d dir=%b mov=%b door=%b arr=%b",
               nm, act[6:4], act[3], act[2], act[1], act[0], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    else
      pass_cnt++;
  endtask

  task automatic step(input string nm, input logic r, input int des, input logic vld,
                      input logic hold, input int now, input logic dir, input logic m,
                      input logic d, input logic a);
    apply(r, des, vld, hold);
    check(nm, {3'(now), dir, m, d, a});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.input_des = 3'd0;
    bus.input_bool = 1'b0;
    bus.input_door_hold = 1'b0;

    // Reset, travel 1->4 with arrival and door cycle, same-floor request, invalid targets.
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 4, 1, 0, 1, 1, 1, 0, 0));
    for (int f = 1; f <= 3; f++) begin
      for (int k = 0; k < 3; k++) tbl.push_back(v(1, 4, 1, 0, f, 1, 1, 0, 0));
      if (f < 3) tbl.push_back(v(1, 4, 1, 0, f + 1, 1, 1, 0, 0));
    end
    tbl.push_back(v(1, 4, 1, 0, 4, 1, 0, 1, 1));
    tbl.push_back(v(1, 4, 1, 0, 4, 1, 0, 1, 0));
    tbl.push_back(v(1, 4, 1, 0, 4, 1, 0, 1, 0));
    tbl.push_back(v(1, 4, 1, 0, 4, 1, 0, 0, 0));
    tbl.push_back(v(1, 4, 1, 0, 4, 1, 0, 1, 1));
    tbl.push_back(v(1, 4, 0, 0, 4, 1, 0, 1, 0));
    tbl.push_back(v(1, 4, 0, 0, 4, 1, 0, 1, 0));
    tbl.push_back(v(1, 4, 0, 0, 4, 1, 0, 0, 0));
    tbl.push_back(v(1, 7, 1, 0, 4, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 4, 1, 0, 0, 0));
    tbl.push_back(v(1, 2, 0, 0, 4, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, int'(tbl[i].des), tbl[i].vld, tbl[i].hold);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Door hold for 5 cycles, then 3 more open cycles after it falls.
    step("hold_entry", 1, 4, 1, 0, 4, 1, 0, 1, 1);
    for (int k = 0; k < 5; k++) step("hold_high", 1, 4, 0, 1, 4, 1, 0, 1, 0);
    step("hold_rel0", 1, 4, 0, 0, 4, 1, 0, 1, 0);
    step("hold_rel1", 1, 4, 0, 0, 4, 1, 0, 1, 0);
    step("hold_close", 1, 4, 0, 0, 4, 1, 0, 0, 0);

    // Hold asserted exactly at door expiry keeps the door open.
    step("exp_entry", 1, 4, 1, 0, 4, 1, 0, 1, 1);
    step("exp_c1", 1, 4, 0, 0, 4, 1, 0, 1, 0);
    step("exp_c2", 1, 4, 0, 0, 4, 1, 0, 1, 0);
    step("exp_hold", 1, 4, 0, 1, 4, 1, 0, 1, 0);
    step("exp_r1", 1, 4, 0, 0, 4, 1, 0, 1, 0);
    step("exp_r2", 1, 4, 0, 0, 4, 1, 0, 1, 0);
    step("exp_close", 1, 4, 0, 0, 4, 1, 0, 0, 0);

    // Retarget mid-segment: heading to 5, changed to 3 between floors 2 and 3.
    step("rt_rst", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("rt_go", 1, 5, 1, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("rt_seg1", 1, 5, 1, 0, 1, 1, 1, 0, 0);
    step("rt_at2", 1, 5, 1, 0, 2, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("rt_seg2", 1, 3, 1, 0, 2, 1, 1, 0, 0);
    step("rt_arrive3", 1, 3, 1, 0, 3, 1, 0, 1, 1);
    step("rt_door1", 1, 3, 0, 0, 3, 1, 0, 1, 0);
    step("rt_door2", 1, 3, 0, 0, 3, 1, 0, 1, 0);
    step("rt_close", 1, 3, 0, 0, 3, 1, 0, 0, 0);

    // Valid dropped mid-segment: segment completes, car idles without arrival.
    step("drop_go", 1, 5, 1, 0, 3, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("drop_seg", 1, 5, 0, 0, 3, 1, 1, 0, 0);
    step("drop_stop", 1, 5, 0, 0, 4, 1, 0, 0, 0);
    step("drop_idle", 1, 5, 0, 0, 4, 1, 0, 0, 0);

    // Downward travel, then reset mid-MOVE at floor 3.
    step("dn_go", 1, 2, 1, 0, 4, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("dn_seg", 1, 2, 1, 0, 4, 0, 1, 0, 0);
    step("dn_at3", 1, 2, 1, 0, 3, 0, 1, 0, 0);
    step("dn_mid", 1, 2, 1, 0, 3, 0, 1, 0, 0);
    step("mv_rst", 0, 2, 1, 0, 1, 1, 0, 0, 0);
    step("post_rst", 1, 0, 0, 0, 1, 1, 0, 0, 0);

    // Full run to the top floor.
    step("top_go", 1, 6, 1, 0, 1, 1, 1, 0, 0);
    for (int f = 2; f <= 6; f++) begin
      for (int k = 0; k < 3; k++) step($sformatf("top_seg%0d", f), 1, 6, 1, 0, f - 1, 1, 1, 0, 0);
      if (f == 6) step("top_arrive", 1, 6, 1, 0, 6, 1, 0, 1, 1);
      else step($sformatf("top_at%0d", f), 1, 6, 1, 0, f, 1, 1, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
